// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM state encoding,
// wait-counter width and the bundle of active-low SRAM control strobes.
package sram_ctrl_pkg;

   // Width of the wait-state down-counter (WAIT_STATES range 0..15).
   localparam int WAIT_W = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ACC   = 3'd1,
      WR_SETUP = 3'd2,
      WR_PULSE = 3'd3,
      WR_HOLD  = 3'd4,
      RESP     = 3'd5
   } state_t;

   // Active-low SRAM strobes, registered together as one word.
   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic ub_n;
      logic lb_n;
   } sram_ctl_t;

   // Bus parked: chip deselected, all strobes inactive.
   localparam sram_ctl_t CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                      ub_n: 1'b1, lb_n: 1'b1};

   // True for the states in which the controller owns the data bus.
   function automatic logic drives_bus(input state_t s);
      return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
   endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter that times the RD_ACC and WR_PULSE phases.
// done_o is high while the count is zero, i.e. on the last cycle of a phase.
module sram_wait_timer
   import sram_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [WAIT_W-1:0] load_val_i,
   input  logic              dec_i,
   output logic              done_o
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   // Load has priority; decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tri_buffer_16.sv
// 16-bit tri-state driver onto a shared bus; releases the bus when disabled.
module tri_buffer_16 (
   input  logic        en_i,
   input  logic [15:0] data_i,
   inout  wire  [15:0] bus_io
);

   assign bus_io = en_i ? data_i : 16'bz;

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller between the LC-3 MAR/MDR and an asynchronous SRAM.
// Converts single-word requests into sequenced SRAM cycles with registered
// active-low strobes and a programmable number of wait states.
//
// Request handshake: the controller accepts a request on a rising edge where
// req_valid and req_ready are both high (req_ready is high only in IDLE).
// Address, write data and byte enables are captured on that edge; later
// changes on req_* have no effect. rsp_valid pulses for one cycle when the
// transaction completes; rsp_rdata holds the last read data.
//
// Optional build macro SRAM_CTRL_BE_EN: when defined, writes honour req_be
// on the UB/LB lanes; when undefined both lanes are enabled on every write.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 20,
   parameter int WAIT_STATES = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [15:0]       req_addr,
   input  logic [15:0]       req_wdata,
   input  logic [1:0]        req_be,
   output logic              rsp_valid,
   output logic [15:0]       rsp_rdata,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [15:0]       SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output state_t            dbg_state_o
);

   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       rdata_q, rdata_d;
   sram_ctl_t         ctl_q, ctl_d;
   logic              drive_q, drive_d;
   logic              ready_q, ready_d;
   logic              rsp_q, rsp_d;
   logic              timer_load, timer_dec, timer_done;
   logic              accept;
   logic [1:0]        lane_n;

   assign accept = (state_q == IDLE) && req_valid;

`ifdef SRAM_CTRL_BE_EN
   logic [1:0] be_q, be_d;

   // Byte enables follow the request on the accept edge, then hold.
   always_comb begin
      be_d = be_q;
      if (accept) begin
         be_d = req_be;
      end
   end

   // Latched byte enables for the duration of a write.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         be_q <= 2'b11;
      end else begin
         be_q <= be_d;
      end
   end

   // be_d already reflects req_be in the accept cycle, so the lanes are
   // correct from the first write-state cycle.
   assign lane_n = ~be_d;
`else
   logic unused_be;
   assign unused_be = ^req_be;
   assign lane_n    = 2'b00;
`endif

   sram_wait_timer u_timer (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .load_i     (timer_load),
      .load_val_i (WAIT_LOAD),
      .dec_i      (timer_dec),
      .done_o     (timer_done)
   );

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; also steers the wait timer.
   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d    = req_we ? WR_SETUP : RD_ACC;
               timer_load = 1'b1;
            end
         end
         RD_ACC: begin
            if (timer_done) state_d = RESP;
            else            timer_dec = 1'b1;
         end
         WR_SETUP: begin
            // Reload so the pulse length is independent of setup timing.
            state_d    = WR_PULSE;
            timer_load = 1'b1;
         end
         WR_PULSE: begin
            if (timer_done) state_d = WR_HOLD;
            else            timer_dec = 1'b1;
         end
         WR_HOLD: state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the upcoming state, so every pin is a flop output.
   always_comb begin
      ctl_d   = CTL_IDLE;
      drive_d = drives_bus(state_d);
      ready_d = 1'b0;
      rsp_d   = 1'b0;
      unique case (state_d)
         IDLE:     ready_d = 1'b1;
         RD_ACC:   ctl_d = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1,
                             ub_n: 1'b0, lb_n: 1'b0};
         WR_SETUP,
         WR_HOLD:  ctl_d = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1,
                             ub_n: lane_n[1], lb_n: lane_n[0]};
         WR_PULSE: ctl_d = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0,
                             ub_n: lane_n[1], lb_n: lane_n[0]};
         RESP:     rsp_d = 1'b1;
         default:  ctl_d = CTL_IDLE;
      endcase
   end

   // Address/data capture: request fields on accept, read data on the last
   // RD_ACC edge.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (accept) begin
         addr_d  = ADDR_W'(req_addr);
         wdata_d = req_wdata;
      end
      if ((state_q == RD_ACC) && timer_done) begin
         rdata_d = SRAM_DQ;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ctl_q   <= CTL_IDLE;
         drive_q <= 1'b0;
         ready_q <= 1'b1;
         rsp_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ctl_q   <= ctl_d;
         drive_q <= drive_d;
         ready_q <= ready_d;
         rsp_q   <= rsp_d;
      end
   end

   // Bus is only driven in write states, where OE_N is always high.
   tri_buffer_16 u_dq_drv (
      .en_i   (drive_q),
      .data_i (wdata_q),
      .bus_io (SRAM_DQ)
   );

   assign req_ready   = ready_q;
   assign rsp_valid   = rsp_q;
   assign rsp_rdata   = rdata_q;
   assign SRAM_ADDR   = addr_q;
   assign SRAM_CE_N   = ctl_q.ce_n;
   assign SRAM_OE_N   = ctl_q.oe_n;
   assign SRAM_WE_N   = ctl_q.we_n;
   assign SRAM_UB_N   = ctl_q.ub_n;
   assign SRAM_LB_N   = ctl_q.lb_n;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_STATES = 1, 0, 15), each with a
// small byte-lane SRAM model. Responses are checked by a scoreboard queue
// holding expected read data and the exact response cycle.
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;

   localparam int N = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic        req_valid [N];
   logic        req_we    [N];
   logic [15:0] req_addr  [N];
   logic [15:0] req_wdata [N];
   logic [1:0]  req_be    [N];
   logic        req_ready [N];
   logic        rsp_valid [N];
   logic [15:0] rsp_rdata [N];
   logic [19:0] sram_addr [N];
   logic [15:0] dq_mon    [N];
   logic        ce_n [N], oe_n [N], we_n [N], ub_n [N], lb_n [N];
   state_t      dbg_state [N];

   logic [15:0] mem [N][256];
   logic        poke_en = 1'b0;
   int          poke_inst = 0;
   logic [7:0]  poke_addr = '0;
   logic [15:0] poke_data = '0;

   function automatic int ws_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_inst
      localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
      wire [15:0] dq;
      wire [15:0] rd;
      wire [19:0] ad;
      wire        rdy, vld, ce, oe, we, ub, lb;
      state_t     st;

      sram_ctrl #(.ADDR_W(20), .WAIT_STATES(WS)) u_dut (
         .Clk         (clk),
         .Reset       (rst),
         .req_valid   (req_valid[g]),
         .req_ready   (rdy),
         .req_we      (req_we[g]),
         .req_addr    (req_addr[g]),
         .req_wdata   (req_wdata[g]),
         .req_be      (req_be[g]),
         .rsp_valid   (vld),
         .rsp_rdata   (rd),
         .SRAM_ADDR   (ad),
         .SRAM_DQ     (dq),
         .SRAM_CE_N   (ce),
         .SRAM_OE_N   (oe),
         .SRAM_WE_N   (we),
         .SRAM_UB_N   (ub),
         .SRAM_LB_N   (lb),
         .dbg_state_o (st)
      );

      // SRAM read: drives the bus while selected, output-enabled, not writing.
      assign dq = (!ce && !oe && we) ? mem[g][ad[7:0]] : 16'hzzzz;

      assign req_ready[g] = rdy;
      assign rsp_valid[g] = vld;
      assign rsp_rdata[g] = rd;
      assign sram_addr[g] = ad;
      assign dq_mon[g]    = dq;
      assign ce_n[g]      = ce;
      assign oe_n[g]      = oe;
      assign we_n[g]      = we;
      assign ub_n[g]      = ub;
      assign lb_n[g]      = lb;
      assign dbg_state[g] = st;
   end

   // SRAM write model (per-lane, while CE and WE are low) plus bench preload.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (poke_en && (poke_inst == i)) begin
            mem[i][poke_addr] <= poke_data;
         end else if (!ce_n[i] && !we_n[i]) begin
            if (!ub_n[i]) mem[i][sram_addr[i][7:0]][15:8] <= dq_mon[i][15:8];
            if (!lb_n[i]) mem[i][sram_addr[i][7:0]][7:0]  <= dq_mon[i][7:0];
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          inst;
      logic        rd;
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sb_check();
      for (int i = 0; i < N; i++) begin
         if (rsp_valid[i]) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: inst %0d rsp_valid=1, expected none (cycle %0d)", i, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rsp_inst", i, e.inst);
               chk("rsp_cycle", cyc, e.due);
               if (e.rd) chk("rsp_rdata", rsp_rdata[i], e.data);
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      sb_check();
   endtask

   task automatic poke(input int inst, input logic [7:0] a, input logic [15:0] d);
      poke_inst = inst;
      poke_addr = a;
      poke_data = d;
      poke_en   = 1'b1;
      tick();
      poke_en   = 1'b0;
   endtask

   // Presents one request in IDLE (cycle 0); returns at cycle 1.
   task automatic issue(input int inst, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        input logic [15:0] exp_data, input bit push);
      exp_t e;
      chk("ready_before_issue", req_ready[inst], 1);
      req_valid[inst] = 1'b1;
      req_we[inst]    = we;
      req_addr[inst]  = addr;
      req_wdata[inst] = wdata;
      req_be[inst]    = be;
      if (push) begin
         e.inst = inst;
         e.rd   = !we;
         e.data = exp_data;
         e.due  = cyc + (we ? ws_of(inst) + 4 : ws_of(inst) + 2);
         exp_q.push_back(e);
      end
      tick();
      req_valid[inst] = 1'b0;
      req_we[inst]    = 1'($urandom_range(0, 1));
      req_addr[inst]  = 16'($urandom);
      req_wdata[inst] = 16'($urandom);
      req_be[inst]    = 2'($urandom_range(0, 3));
   endtask

   // Runs until all expected responses arrive (bounded), then one more
   // cycle so the controller is back in IDLE.
   task automatic wait_done();
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
      chk("pending_after_timeout", exp_q.size(), 0);
      exp_q.delete();
      tick();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] pre;
      logic [15:0] exp;
   } vec_t;

   vec_t vt [6];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int we_low;
      int c0;

      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = '0;
         req_wdata[i] = '0;
         req_be[i]    = 2'b11;
      end

`ifdef SRAM_CTRL_BE_EN
      vt[0] = '{1'b0, 16'h00C3, 16'h0000, 2'b11, 16'h0F0F, 16'h0F0F};
      vt[1] = '{1'b1, 16'h0077, 16'h1234, 2'b01, 16'hFFFF, 16'hFF34};
      vt[2] = '{1'b1, 16'h0078, 16'hABCD, 2'b10, 16'h0000, 16'hAB00};
      vt[3] = '{1'b1, 16'h0079, 16'h5555, 2'b00, 16'h1111, 16'h1111};
`else
      vt[0] = '{1'b0, 16'h00C3, 16'h0000, 2'b11, 16'h0F0F, 16'h0F0F};
      vt[1] = '{1'b1, 16'h0077, 16'h1234, 2'b01, 16'hFFFF, 16'h1234};
      vt[2] = '{1'b1, 16'h0078, 16'hABCD, 2'b10, 16'h0000, 16'hABCD};
      vt[3] = '{1'b1, 16'h0079, 16'h5555, 2'b00, 16'h1111, 16'h5555};
`endif
      vt[4] = '{1'b1, 16'h00A0, 16'hC3C3, 2'b11, 16'h0000, 16'hC3C3};
      vt[5] = '{1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h8001, 16'h8001};

      // Reset values on every instance.
      rst = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < N; i++) begin
         chk("rst_ce_n", ce_n[i], 1);
         chk("rst_oe_n", oe_n[i], 1);
         chk("rst_we_n", we_n[i], 1);
         chk("rst_ub_n", ub_n[i], 1);
         chk("rst_lb_n", lb_n[i], 1);
         chk("rst_ready", req_ready[i], 1);
         chk("rst_rsp_valid", rsp_valid[i], 0);
         chk("rst_rdata", rsp_rdata[i], 0);
         chk("rst_addr", sram_addr[i], 0);
         chk("rst_state", dbg_state[i], IDLE);
      end
      rst = 1'b0;
      tick();

      // Reset during WR_PULSE abandons the write without a response.
      poke(0, 8'h50, 16'h0000);
      issue(0, 1'b1, 16'h0050, 16'h7777, 2'b11, 16'h0000, 1'b0);
      tick();
      chk("midrst_pulse_we_n", we_n[0], 0);
      rst = 1'b1;
      tick();
      chk("midrst_we_n", we_n[0], 1);
      chk("midrst_ce_n", ce_n[0], 1);
      chk("midrst_ready", req_ready[0], 1);
      chk("midrst_state", dbg_state[0], IDLE);
      chk("midrst_addr", sram_addr[0], 0);
      chk("midrst_rsp_valid", rsp_valid[0], 0);
      rst = 1'b0;
      repeat (6) tick();

      // Read, WAIT_STATES = 1: OE low in cycles 1-2, response in cycle 3.
      poke(0, 8'h34, 16'hBEEF);
      issue(0, 1'b0, 16'h1234, 16'h0000, 2'b11, 16'hBEEF, 1'b1);
      chk("rd_c1_oe_n", oe_n[0], 0);
      chk("rd_c1_ce_n", ce_n[0], 0);
      chk("rd_c1_we_n", we_n[0], 1);
      chk("rd_c1_addr", sram_addr[0], 20'h01234);
      chk("rd_c1_ready", req_ready[0], 0);
      tick();
      chk("rd_c2_oe_n", oe_n[0], 0);
      chk("rd_c2_ub_n", ub_n[0], 0);
      chk("rd_c2_lb_n", lb_n[0], 0);
      tick();
      chk("rd_c3_oe_n", oe_n[0], 1);
      chk("rd_c3_ready", req_ready[0], 0);
      chk("rd_c3_state", dbg_state[0], RESP);
      tick();
      chk("rd_idle_ready", req_ready[0], 1);
      chk("rd_addr_hold", sram_addr[0], 20'h01234);
      chk("rd_queue_empty", exp_q.size(), 0);

      // Write, WAIT_STATES = 1: DQ driven cycles 1-4, WE low for 2 cycles.
      poke(0, 8'h42, 16'h0000);
      issue(0, 1'b1, 16'h0042, 16'hA5A5, 2'b11, 16'h0000, 1'b1);
      we_low = 0;
      for (int k = 1; k <= 4; k++) begin
         if (!we_n[0]) we_low++;
         chk("wr_dq", dq_mon[0], 16'hA5A5);
         chk("wr_ce_n", ce_n[0], 0);
         chk("wr_oe_n", oe_n[0], 1);
         tick();
      end
      chk("wr_we_low_cycles", we_low, 2);
      chk("wr_c5_we_n", we_n[0], 1);
      tick();
      chk("wr_mem", mem[0][8'h42], 16'hA5A5);
      chk("wr_queue_empty", exp_q.size(), 0);

      // Table of reads and writes with byte-enable patterns.
      for (int v = 0; v < 6; v++) begin
         poke(0, vt[v].addr[7:0], vt[v].pre);
         issue(0, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].be, vt[v].exp, 1'b1);
         chk("vec_addr", sram_addr[0], {4'h0, vt[v].addr});
         wait_done();
         if (vt[v].we) chk("vec_mem", mem[0][vt[v].addr[7:0]], vt[v].exp);
      end

      // WAIT_STATES = 0, request held high: one response every 3 cycles,
      // and the request is ignored while the controller sits in RESP.
      poke(1, 8'h10, 16'h1357);
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b0;
      req_addr[1]  = 16'h0010;
      req_be[1]    = 2'b11;
      c0 = cyc;
      for (int r = 0; r < 3; r++) begin
         exp_t e;
         e.inst = 1;
         e.rd   = 1'b1;
         e.data = 16'h1357;
         e.due  = c0 + 2 + 3 * r;
         exp_q.push_back(e);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 2 || k == 5) chk("b2b_resp_ready", req_ready[1], 0);
         if (k == 2 || k == 5) chk("b2b_resp_state", dbg_state[1], RESP);
         if (k == 3 || k == 6) chk("b2b_idle_ready", req_ready[1], 1);
         if (k == 7) req_valid[1] = 1'b0;
      end
      chk("b2b_queue_empty", exp_q.size(), 0);
      tick();
      chk("b2b_final_ready", req_ready[1], 1);

      // WAIT_STATES = 15: read responds in cycle 17; a later write leaves
      // rsp_rdata untouched.
      poke(2, 8'h20, 16'h2468);
      issue(2, 1'b0, 16'h0020, 16'h0000, 2'b11, 16'h2468, 1'b1);
      wait_done();
      chk("ws15_rdata", rsp_rdata[2], 16'h2468);
      poke(2, 8'h21, 16'h0000);
      issue(2, 1'b1, 16'h0021, 16'h9999, 2'b11, 16'h0000, 1'b1);
      wait_done();
      chk("ws15_rdata_hold", rsp_rdata[2], 16'h2468);
      chk("ws15_mem", mem[2][8'h21], 16'h9999);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
